// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b processed LSB first through one full-subtractor cell.
// Start/busy/done handshake; diff/borrow/overflow registers update only on completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             bout;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    function automatic logic diff_bit(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // Signed overflow only possible when operand signs differ and the result sign leaves the minuend's.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sd);
        return (sa != sb) && (sd != sa);
    endfunction

    always_comb begin
        d        = diff_bit(a_sh[0], b_sh[0], bin);
        bout     = borrow_bit(a_sh[0], b_sh[0], bin);
        res_cat  = {d, res};
        res_next = res_cat[WIDTH:1];
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            bin      <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            bin  <= bout;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                diff     <= res_next;
                borrow   <= bout;
                overflow <= signed_ovf(a_msb, b_msb, res_next[WIDTH-1]);
            end
        end else begin
            // The single DONE cycle also serves as an accept window so back-to-back issue is WIDTH+1 cycles.
            done <= 1'b0;
            if (start) begin
                state <= SHIFT;
                busy  <= 1'b1;
                a_sh  <= a;
                b_sh  <= b;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                res   <= '0;
                bin   <= 1'b0;
                cnt   <= '0;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule
